// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: forwarding-select encodings and the PC register index.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam logic [3:0] PC_REG = 4'd15;

  // Memory stage wins over Writeback: it holds the younger result.
  function automatic fwd_sel_e fwd_select(input logic match_m, input logic match_w);
    if (match_m)      return FWD_M;
    else if (match_w) return FWD_W;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of the E/M/W register addresses so the datapath need not export them.
module hazard_shadow_pipe #(
  parameter int RA_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [RA_W-1:0] ra1_d_i,
  input  logic [RA_W-1:0] ra2_d_i,
  input  logic [RA_W-1:0] wa3_d_i,
  output logic [RA_W-1:0] ra1_e_o,
  output logic [RA_W-1:0] ra2_e_o,
  output logic [RA_W-1:0] wa3_e_o,
  output logic [RA_W-1:0] wa3_m_o,
  output logic [RA_W-1:0] wa3_w_o
);

  logic [RA_W-1:0] ra1_e_q, ra2_e_q, wa3_e_q, wa3_m_q, wa3_w_q;
  logic [RA_W-1:0] ra1_e_d, ra2_e_d, wa3_e_d;

  // A flush inserts a bubble into Execute; M and W always advance.
  always_comb begin
    ra1_e_d = ra1_d_i;
    ra2_e_d = ra2_d_i;
    wa3_e_d = wa3_d_i;
    if (flush_i) begin
      ra1_e_d = '0;
      ra2_e_d = '0;
      wa3_e_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ra1_e_q <= '0;
      ra2_e_q <= '0;
      wa3_e_q <= '0;
      wa3_m_q <= '0;
      wa3_w_q <= '0;
    end else begin
      ra1_e_q <= ra1_e_d;
      ra2_e_q <= ra2_e_d;
      wa3_e_q <= wa3_e_d;
      wa3_m_q <= wa3_e_q;
      wa3_w_q <= wa3_m_q;
    end
  end

  assign ra1_e_o = ra1_e_q;
  assign ra2_e_o = ra2_e_q;
  assign wa3_e_o = wa3_e_q;
  assign wa3_m_o = wa3_m_q;
  assign wa3_w_o = wa3_w_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall and control-flow flushes.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int RA_W  = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  RA1D,
  input  logic [RA_W-1:0]  RA2D,
  input  logic [RA_W-1:0]  WA3D,
  input  logic             MemtoRegE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             BranchTakenE,
  input  logic             PCWrPendingF,
  input  logic             PCSrcW,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic [RA_W-1:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  logic            match1_m, match2_m, match1_w, match2_w;
  logic            ldr_stall;

  hazard_shadow_pipe #(.RA_W(RA_W)) u_shadow (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (FlushE),
    .ra1_d_i (RA1D),
    .ra2_d_i (RA2D),
    .wa3_d_i (WA3D),
    .ra1_e_o (ra1_e),
    .ra2_e_o (ra2_e),
    .wa3_e_o (wa3_e),
    .wa3_m_o (wa3_m),
    .wa3_w_o (wa3_w)
  );

  always_comb begin
    match1_m  = RegWriteM && (wa3_m == ra1_e) && (ra1_e != RA_W'(PC_REG));
    match2_m  = RegWriteM && (wa3_m == ra2_e) && (ra2_e != RA_W'(PC_REG));
    match1_w  = RegWriteW && (wa3_w == ra1_e) && (ra1_e != RA_W'(PC_REG));
    match2_w  = RegWriteW && (wa3_w == ra2_e) && (ra2_e != RA_W'(PC_REG));
    ldr_stall = MemtoRegE && ((RA1D == wa3_e) || (RA2D == wa3_e));

    StallD    = ldr_stall;
    StallF    = ldr_stall || PCWrPendingF;
    FlushD    = PCWrPendingF || PCSrcW || BranchTakenE;
    FlushE    = ldr_stall || BranchTakenE;
    ForwardAE = fwd_select(match1_m, match1_w);
    ForwardBE = fwd_select(match2_m, match2_w);

    if (reset) begin
      StallD    = 1'b0;
      StallF    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: stop at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (FlushE && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic against a reference model.
module tb_hazard_unit;

  localparam int RA_W  = 4;
  localparam int CNT_W = 4;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [RA_W-1:0]  RA1D, RA2D, WA3D;
  logic             MemtoRegE, RegWriteM, RegWriteW, BranchTakenE, PCWrPendingF, PCSrcW;
  logic             StallF, StallD, FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  hazard_unit #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .WA3D         (WA3D),
    .MemtoRegE    (MemtoRegE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .BranchTakenE (BranchTakenE),
    .PCWrPendingF (PCWrPendingF),
    .PCSrcW       (PCSrcW),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the instruction sitting in each stage, as plain integers.
  typedef struct {
    int unsigned ra1;
    int unsigned ra2;
    int unsigned wa3;
  } instr_t;

  instr_t      m_e;
  int unsigned m_wa3_m, m_wa3_w;
  int unsigned m_scnt, m_fcnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ldr();
    return MemtoRegE && (int'(RA1D) == m_e.wa3 || int'(RA2D) == m_e.wa3);
  endfunction

  function automatic logic [1:0] m_fwd(input int unsigned ra);
    if (ra == 15)                      return 2'b00;
    if (RegWriteM && m_wa3_m == ra)    return 2'b10;
    if (RegWriteW && m_wa3_w == ra)    return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_e = '{0, 0, 0};
    m_wa3_m = 0;
    m_wa3_w = 0;
    m_scnt  = 0;
    m_fcnt  = 0;
  endtask

  task automatic check_all();
    bit ldr, fe;
    ldr = m_ldr();
    fe  = ldr || BranchTakenE;
    if (reset) begin
      check("StallF", StallF, 0);
      check("StallD", StallD, 0);
      check("FlushD", FlushD, 0);
      check("FlushE", FlushE, 0);
      check("FwdA",   ForwardAE, 0);
      check("FwdB",   ForwardBE, 0);
    end else begin
      check("StallF", StallF, ldr || PCWrPendingF);
      check("StallD", StallD, ldr);
      check("FlushD", FlushD, PCWrPendingF || PCSrcW || BranchTakenE);
      check("FlushE", FlushE, fe);
      check("FwdA",   ForwardAE, m_fwd(m_e.ra1));
      check("FwdB",   ForwardBE, m_fwd(m_e.ra2));
    end
    check("StallCnt", StallCnt, m_scnt);
    check("FlushCnt", FlushCnt, m_fcnt);
  endtask

  task automatic drive(input int unsigned ra1, input int unsigned ra2, input int unsigned wa3,
                       input bit mtr, input bit rwm, input bit rww,
                       input bit bt, input bit pcp, input bit pcs);
    RA1D = RA_W'(ra1); RA2D = RA_W'(ra2); WA3D = RA_W'(wa3);
    MemtoRegE = mtr; RegWriteM = rwm; RegWriteW = rww;
    BranchTakenE = bt; PCWrPendingF = pcp; PCSrcW = pcs;
    #1;
    if (reset) model_reset();
    check_all();
  endtask

  // Advance one clock; the model steps using the inputs held across the edge.
  task automatic tick();
    bit ldr, fe;
    @(posedge clk);
    if (!reset) begin
      ldr = m_ldr();
      fe  = ldr || BranchTakenE;
      if (PERF && ldr && m_scnt < CNT_MAX) m_scnt++;
      if (PERF && fe  && m_fcnt < CNT_MAX) m_fcnt++;
      m_wa3_w = m_wa3_m;
      m_wa3_m = m_e.wa3;
      m_e     = fe ? '{0, 0, 0} : '{int'(RA1D), int'(RA2D), int'(WA3D)};
    end
    @(negedge clk);
  endtask

  initial begin
    int unsigned r[3];
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;

    // Forward from M on SrcA only.
    drive(0, 0, 3, 0, 0, 0, 0, 0, 0); tick();
    drive(3, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    check("fwdM_A", ForwardAE, 2'b10);
    check("fwdM_B", ForwardBE, 2'b00);
    tick();

    // M beats W; W alone selects 01.
    drive(0, 0, 5, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 5, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 5, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 1, 1, 0, 0, 0);
    check("prio_M", ForwardBE, 2'b10);
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0);
    check("prio_W", ForwardBE, 2'b01);
    tick();

    // R15 is never forwarded.
    drive(0, 0, 15, 0, 0, 0, 0, 0, 0); tick();
    drive(15, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 1, 1, 0, 0, 0);
    check("r15", ForwardAE, 2'b00);
    tick();

    // Load-use stall then bubble.
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 7, 0, 1, 0, 0, 0, 0, 0);
    check("ldr_F", StallF, 1'b1);
    check("ldr_D", StallD, 1'b1);
    check("ldr_E", FlushE, 1'b1);
    tick();
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0);
    check("bubble", StallD, 1'b0);
    tick();

    // Branch during a load-use stall; then PC write pending alone.
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0); tick();
    drive(7, 2, 0, 1, 0, 0, 1, 0, 0);
    check("bs_FD", FlushD, 1'b1);
    check("bs_FE", FlushE, 1'b1);
    check("bs_SD", StallD, 1'b1);
    tick();
    drive(1, 2, 3, 0, 0, 0, 0, 1, 0);
    check("pcp_SF", StallF, 1'b1);
    check("pcp_FD", FlushD, 1'b1);
    check("pcp_FE", FlushE, 1'b0);
    tick();

    // Counters: three stall cycles, then asynchronous reset mid-count.
    reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0); tick();
    end
    drive(4, 4, 4, 0, 1, 1, 0, 0, 0);
    check("scnt3", StallCnt, PERF ? CNT_W'(3) : CNT_W'(0));
    #2 reset = 1'b1;
    drive(0, 0, 0, 1, 1, 1, 1, 1, 1);
    check("rst_cnt", StallCnt, 0);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst", StallD, 1'b0);
    tick();

    // Saturation.
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0); tick();
    end
    drive(1, 2, 3, 0, 0, 0, 0, 0, 0);
    check("sat", StallCnt, PERF ? CNT_W'(CNT_MAX) : CNT_W'(0));
    tick();

    // Randomized traffic; small address range (plus R15) to provoke matches.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < 3; k++) begin
        r[k] = $urandom_range(0, 4);
        if (r[k] == 4) r[k] = 15;
      end
      drive(r[0], r[1], r[2], ($urandom_range(0, 2) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
